// File: rtl/sr_cfg_pkg.sv
// sr_cfg_pkg: shared FSM encodings and default geometry for the shift-register config arbiter
package sr_cfg_pkg;
  localparam int DEF_DATA_WIDTH = 170;
  localparam int DEF_N_REQ = 4;
  localparam logic [5:0] ST_IDLE  = 6'b000001;
  localparam logic [5:0] ST_GRANT = 6'b000010;
  localparam logic [5:0] ST_SHIFT = 6'b000100;
  localparam logic [5:0] ST_LOAD  = 6'b001000;
  localparam logic [5:0] ST_GAP   = 6'b010000;
  localparam logic [5:0] ST_DONE  = 6'b100000;
endpackage

// File: rtl/sr_serializer.sv
// sr_serializer: shadow word register shifted out LSB first, with a count of bits shifted
// ports: clk/rst (async, active-high); load captures word and clears the count;
// shift drops one bit and counts it; bit_out is the next bit to send;
// last is high once DATA_WIDTH bits have been shifted.
module sr_serializer
  import sr_cfg_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] word,
  output logic                  bit_out,
  output logic                  last
);
  logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  always_comb begin
    shadow_d = load ? word : shift ? shadow_q >> 1 : shadow_q;
    count_d = load ? '0 : shift ? count_q + 1'b1 : count_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      count_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      count_q <= count_d;
    end
  end
  assign bit_out = shadow_q[0];
  assign last = count_q == CNT_WIDTH'(DATA_WIDTH);
endmodule

// File: rtl/sr_cfg_arbiter.sv
// sr_cfg_arbiter: round-robin arbiter that serializes one requester's word into its config chain
// ports: clk/rst (async, active-high); req level requests; din_flat packed words;
// abort cancels an active transfer; gnt/done one-cycle one-hot pulses; busy outside IDLE;
// sr_sel/sr_din/sr_clk_en/sr_load drive the selected chain. All outputs are flops.
module sr_cfg_arbiter
  import sr_cfg_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N_REQ = DEF_N_REQ,
  parameter int CNT_WIDTH = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*DATA_WIDTH-1:0] din_flat,
  input  logic                        abort,
  output logic [N_REQ-1:0]            gnt,
  output logic [N_REQ-1:0]            done,
  output logic                        busy,
  output logic [N_REQ-1:0]            sr_sel,
  output logic                        sr_din,
  output logic                        sr_clk_en,
  output logic                        sr_load
);
  localparam int PW = $clog2(N_REQ);
  logic [5:0] state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, win, cand;
  logic [3:0] gap_q, gap_d;
  logic [N_REQ-1:0] gnt_q, gnt_d, done_q, done_d, sel_q, sel_d, win_oh;
  logic busy_q, busy_d, din_q, din_d, clk_en_q, clk_en_d, load_q, load_d;
  logic grant, ser_bit, ser_last, gap_end;
  // descending scan so the requester closest to ptr is the last (winning) assignment
  always_comb begin
    win = ptr_q;
    cand = ptr_q;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      cand = PW'((int'(ptr_q) + j) % N_REQ);
      if (req[cand]) win = cand;
    end
  end
  assign win_oh = N_REQ'(1) << win;
  assign gap_end = gap_q == 4'(GAP_CYCLES - 1);
  // abort only matters in the transfer states; IDLE and DONE are resolved before it
  always_comb begin
    state_d = state_q == ST_IDLE  ? (|req ? ST_GRANT : ST_IDLE)
            : state_q == ST_DONE  ? ST_IDLE
            : abort               ? ST_IDLE
            : state_q == ST_GRANT ? ST_SHIFT
            : state_q == ST_SHIFT ? (ser_last ? ST_LOAD : ST_SHIFT)
            : state_q == ST_LOAD  ? ST_GAP
            : state_q == ST_GAP   ? (gap_end ? ST_DONE : ST_GAP)
            : ST_IDLE;
    grant = state_d == ST_GRANT;
    ptr_d = grant ? PW'((int'(win) + 1) % N_REQ) : ptr_q;
    gap_d = state_q == ST_GAP ? gap_q + 4'd1 : 4'd0;
    gnt_d = grant ? win_oh : '0;
    sel_d = state_d == ST_IDLE ? '0 : grant ? win_oh : sel_q;
    done_d = state_d == ST_DONE ? sel_q : '0;
    busy_d = state_d != ST_IDLE;
    din_d = state_d == ST_SHIFT && ser_bit;
    clk_en_d = state_d == ST_SHIFT || state_d == ST_LOAD;
    load_d = state_d == ST_LOAD;
  end
  sr_serializer #(.DATA_WIDTH(DATA_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_ser (
    .clk    (clk),
    .rst    (rst),
    .load   (grant),
    .shift  (state_d == ST_SHIFT),
    .word   (din_flat[int'(win)*DATA_WIDTH +: DATA_WIDTH]),
    .bit_out(ser_bit),
    .last   (ser_last)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q <= '0;
      gap_q <= '0;
      gnt_q <= '0;
      done_q <= '0;
      sel_q <= '0;
      busy_q <= 1'b0;
      din_q <= 1'b0;
      clk_en_q <= 1'b0;
      load_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      gap_q <= gap_d;
      gnt_q <= gnt_d;
      done_q <= done_d;
      sel_q <= sel_d;
      busy_q <= busy_d;
      din_q <= din_d;
      clk_en_q <= clk_en_d;
      load_q <= load_d;
    end
  end
  assign gnt = gnt_q;
  assign done = done_q;
  assign busy = busy_q;
  assign sr_sel = sel_q;
  assign sr_din = din_q;
  assign sr_clk_en = clk_en_q;
  assign sr_load = load_q;
endmodule

// File: tb/tb_sr_cfg_arbiter.sv
// tb_sr_cfg_arbiter: randomized and directed bench against a transfer-offset reference model
module tb_sr_cfg_arbiter;
  localparam int DW = 170;
  localparam int N = 4;
  localparam int GAP = 2;
  localparam int DONE_OFF = DW + GAP + 2;
  logic clk = 1'b0, rst = 1'b0, abort = 1'b0;
  logic busy, sr_din, sr_clk_en, sr_load;
  logic [N-1:0] req = '0, gnt, done, sr_sel;
  logic [N*DW-1:0] din_flat = '0;
  int checks = 0, errors = 0, cyc = 0;
  int off = -1, cur = 0, ptr = 0;
  logic [DW-1:0] word = '0, obs = '0, saved = '0;
  int gq[$];
  int gnt_cyc = -1, load_cyc = -1, done_cyc = -1, last_done = -1, mingap = 1000;
  int ones = 0, nload = 0, ndone = 0, nbits = 0;

  always #5 clk = ~clk;

  sr_cfg_arbiter #(.DATA_WIDTH(DW), .N_REQ(N), .CNT_WIDTH(8), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .req(req), .din_flat(din_flat), .abort(abort),
    .gnt(gnt), .done(done), .busy(busy), .sr_sel(sr_sel), .sr_din(sr_din),
    .sr_clk_en(sr_clk_en), .sr_load(sr_load)
  );

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // off = cycles since the grant of the current transfer, -1 when idle
  task automatic model_step();
    if (rst) begin
      off = -1;
      ptr = 0;
    end else if (off == -1) begin
      if (req != 0) begin
        for (int j = 0; j < N; j++)
          if (req[(ptr + j) % N]) begin
            cur = (ptr + j) % N;
            break;
          end
        off = 0;
        word = din_flat[cur*DW +: DW];
        ptr = (cur + 1) % N;
      end
    end else if (off == DONE_OFF || abort) off = -1;
    else off++;
  endtask

  task automatic compare();
    logic [N-1:0] oh;
    oh = off >= 0 ? N'(1) << cur : '0;
    chk("gnt", gnt, off == 0 ? oh : '0);
    chk("busy", busy, off >= 0);
    chk("sr_sel", sr_sel, oh);
    chk("sr_din", sr_din, (off >= 1 && off <= DW) ? word[off-1] : 1'b0);
    chk("sr_clk_en", sr_clk_en, off >= 1 && off <= DW + 1);
    chk("sr_load", sr_load, off == DW + 1);
    chk("done", done, off == DONE_OFF ? oh : '0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    compare();
    if (|gnt) begin
      gq.push_back($clog2(gnt));
      gnt_cyc = cyc;
      if (last_done >= 0 && cyc - last_done < mingap) mingap = cyc - last_done;
    end
    if (sr_load) begin
      load_cyc = cyc;
      nload++;
    end
    if (|done) begin
      done_cyc = cyc;
      last_done = cyc;
      ndone++;
    end
    if (sr_din) ones++;
    if (sr_clk_en && !sr_load && nbits < DW) begin
      obs[nbits] = sr_din;
      nbits++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_async_busy", busy, 0);
    chk("rst_async_clk_en", sr_clk_en, 0);
    chk("rst_async_load", sr_load, 0);
    chk("rst_async_sel", sr_sel, 0);
    chk("rst_async_din", sr_din, 0);
    repeat (2) tick();
    rst = 1'b0;
    last_done = -1;
  endtask

  task automatic wait_gnt(int lim);
    int n;
    n = 0;
    while (gnt == 0 && n < lim) begin
      tick();
      n++;
    end
    chk("gnt_timeout", |gnt, 1);
  endtask

  task automatic run_grants(int cnt);
    int n;
    n = 0;
    while (gq.size() < cnt && n < cnt * (DONE_OFF + 4)) begin
      tick();
      n++;
    end
  endtask

  task automatic fill_din();
    for (int b = 0; b < N*DW; b++) din_flat[b] = 1'($urandom_range(1, 0));
  endtask

  initial begin
    #2;
    do_reset();
    // single word 1 from requester 0: latency and one-hot bit position
    fill_din();
    din_flat[DW-1:0] = '0;
    din_flat[0] = 1'b1;
    req = 4'b0001;
    wait_gnt(5);
    req = '0;
    ones = 0;
    repeat (DONE_OFF + 1) tick();
    chk("lat_load", load_cyc - gnt_cyc, DW + 1);
    chk("lat_done", done_cyc - gnt_cyc, DONE_OFF);
    chk("din_ones", ones, 1);
    // word changes right after the grant must not leak into the shifted bits
    fill_din();
    req = 4'b0100;
    wait_gnt(5);
    saved = din_flat[2*DW +: DW];
    req = '0;
    nbits = 0;
    tick();
    fill_din();
    repeat (DONE_OFF + 1) tick();
    chk("captured_bits", nbits, DW);
    chk("captured_lo", obs[63:0], saved[63:0]);
    chk("captured_hi", obs[DW-1 -: 64], saved[DW-1 -: 64]);
    // two requesters held: alternate, done then next grant two cycles later
    do_reset();
    req = 4'b1010;
    gq.delete();
    mingap = 1000;
    run_grants(4);
    req = '0;
    repeat (DONE_OFF + 2) tick();
    chk("alt_g0", gq.size() > 0 ? gq[0] : -1, 1);
    chk("alt_g1", gq.size() > 1 ? gq[1] : -1, 3);
    chk("alt_g2", gq.size() > 2 ? gq[2] : -1, 1);
    chk("alt_g3", gq.size() > 3 ? gq[3] : -1, 3);
    chk("done_gnt_gap", mingap, 2);
    // all requesting: full rotation
    do_reset();
    req = 4'b1111;
    gq.delete();
    run_grants(5);
    req = '0;
    repeat (DONE_OFF + 2) tick();
    for (int i = 0; i < 5; i++) chk("rot", gq.size() > i ? gq[i] : -1, i % N);
    // abort at shift cycle 50
    do_reset();
    req = 4'b0001;
    wait_gnt(5);
    req = '0;
    repeat (51) tick();
    abort = 1'b1;
    nload = 0;
    ndone = 0;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    repeat (DONE_OFF) tick();
    chk("abort_no_load", nload, 0);
    chk("abort_no_done", ndone, 0);
    req = 4'b1111;
    wait_gnt(5);
    chk("abort_next_gnt", gnt, 4'b0010);
    req = '0;
    repeat (DONE_OFF + 1) tick();
    // reset at shift cycle 100 restores ptr to 0
    req = 4'b0100;
    wait_gnt(5);
    req = '0;
    repeat (101) tick();
    ndone = 0;
    do_reset();
    req = 4'b1100;
    wait_gnt(5);
    chk("post_rst_gnt", gnt, 4'b0100);
    chk("post_rst_no_done", ndone, 0);
    req = '0;
    repeat (DONE_OFF + 1) tick();
    // random traffic
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(7, 0) == 0) req = N'($urandom_range(15, 0));
      abort = $urandom_range(299, 0) == 0;
      if (off != 0 && $urandom_range(15, 0) == 0) fill_din();
      if ($urandom_range(2999, 0) == 0) do_reset();
      else tick();
    end
    abort = 1'b0;
    req = '0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
